// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: IDLE/BUSY/DONE handshake to a single-ack data bus.
// Optional BUSY-state timeout abort is compiled in when DMEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] nextState;
  logic       reqPresent;
  logic       startXfer;
  logic       ackXfer;
  logic       timeoutHit;

  // The timeout counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be in 1..256");
  end

  assign reqPresent = mem_read | mem_write;
  assign startXfer  = (state == IDLE) && reqPresent;
  assign ackXfer    = (state == BUSY) && bus_ack;
  assign stall      = startXfer || (state == BUSY);

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] timeoutCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      timeoutCount <= 8'd0;
    end else if (startXfer) begin
      timeoutCount <= 8'd0;
    end else if ((state == BUSY) && !bus_ack) begin
      timeoutCount <= timeoutCount + 8'd1;
    end
  end

  // An ack on the limit cycle takes priority over the abort.
  assign timeoutHit = (state == BUSY) && !bus_ack &&
                      (timeoutCount == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (timeoutHit) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign bus_err    = 1'b0;
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (reqPresent) nextState = BUSY;
      BUSY:    if (bus_ack || timeoutHit) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // bus_req is registered from the next state so it is high exactly in BUSY cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      rdata_out <= 32'd0;
    end else begin
      state   <= nextState;
      bus_req <= (nextState == BUSY);
      if (startXfer) begin
        bus_addr  <= addr;
        bus_wdata <= wdata;
        bus_we    <= mem_write;
      end
      if (ackXfer && !bus_we) begin
        rdata_out <= bus_rdata;
      end else if (timeoutHit) begin
        rdata_out <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table through a scoreboard plus hand sequences
// for reset, spurious ack, reset-in-BUSY and (with DMEM_TIMEOUT_EN) the timeout abort.
module tb_mem_access_ctrl;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ackDelay;
    logic [31:0] ackData;
    logic [31:0] expRdata;
    logic        expWe;
    int          expStall;
    int          expReq;
    logic        expErr;
  } Vector;

  typedef struct {
    logic [31:0] expRdata;
    logic        expWe;
    int          expStall;
    int          expReq;
    logic        expErr;
  } Expectation;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata_out;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int testsRun = 0;
  int testsFailed = 0;
  Expectation scoreboard[$];
  Vector vectors[7];

  mem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata_out(rdata_out),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic Vector mk(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input int dly, input logic [31:0] ackData, input logic [31:0] expRdata,
                               input logic expWe, input int expStall, input int expReq, input logic expErr);
    Vector v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.ackDelay = dly; v.ackData = ackData;
    v.expRdata = expRdata; v.expWe = expWe; v.expStall = expStall; v.expReq = expReq; v.expErr = expErr;
    return v;
  endfunction

  // One full transfer: request, BUSY with ack after ackDelay cycles, DONE, then back to IDLE.
  task automatic applyStimulus(input Vector v, input string tag);
    int stallCount;
    int reqCount;
    bit reachedDone;
    bit recovered;
    Expectation e;
    @(negedge clk);
    reset = 1'b0; mem_read = v.rd; mem_write = v.wr; addr = v.addr; wdata = v.wdata;
    bus_ack = 1'b0; bus_rdata = $urandom;
    #1;
    stallCount = int'(stall);
    reqCount = int'(bus_req);
    e.expRdata = v.expRdata; e.expWe = v.expWe; e.expStall = v.expStall;
    e.expReq = v.expReq; e.expErr = v.expErr;
    scoreboard.push_back(e);
    reachedDone = 1'b0;
    for (int cyc = 0; cyc < 64 && !reachedDone; cyc++) begin
      @(negedge clk);
      bus_ack = (cyc == v.ackDelay);
      bus_rdata = bus_ack ? v.ackData : $urandom;
      #1;
      if (!stall && !bus_req) begin
        reachedDone = 1'b1;
      end else begin
        stallCount += int'(stall);
        reqCount += int'(bus_req);
        checkOutput({tag, ".busAddr"}, bus_addr, v.addr);
        checkOutput({tag, ".busWdata"}, bus_wdata, v.wdata);
        checkOutput({tag, ".busWe"}, 32'(bus_we), 32'(v.expWe));
      end
    end
    if (!reachedDone) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s.done: transfer still busy after 64 cycles, expected DONE", tag);
      recovered = 1'b0;
      for (int cyc = 0; cyc < 40 && !recovered; cyc++) begin
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b1;
        #1;
        recovered = !stall && !bus_req;
      end
    end
    if (scoreboard.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s.scoreboard: got empty queue, expected one entry", tag);
    end else begin
      e = scoreboard.pop_front();
      checkOutput({tag, ".rdataOut"}, rdata_out, e.expRdata);
      checkOutput({tag, ".doneWe"}, 32'(bus_we), 32'(e.expWe));
      checkOutput({tag, ".stallCycles"}, 32'(stallCount), 32'(e.expStall));
      checkOutput({tag, ".reqCycles"}, 32'(reqCount), 32'(e.expReq));
      checkOutput({tag, ".busErr"}, 32'(bus_err), 32'(e.expErr));
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    #1;
    checkOutput({tag, ".idleStall"}, 32'(stall), 32'd0);
    checkOutput({tag, ".idleReq"}, 32'(bus_req), 32'd0);
  endtask

  initial begin
    int busyCount;
    bit sawDone;

    vectors[0] = mk(1'b1, 1'b0, 32'h100, 32'h0,        2,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 4,  3,  1'b0);
    vectors[1] = mk(1'b0, 1'b1, 32'h204, 32'h12345678, 0,  32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 2,  1,  1'b0);
    vectors[2] = mk(1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 1,  32'h11111111, 32'hCAFEF00D, 1'b1, 3,  2,  1'b0);
    vectors[3] = mk(1'b1, 1'b0, 32'h400, 32'h0,        0,  32'h0BADBEEF, 32'h0BADBEEF, 1'b0, 2,  1,  1'b0);
    vectors[4] = mk(1'b1, 1'b0, 32'h404, 32'h0,        5,  32'h76543210, 32'h76543210, 1'b0, 7,  6,  1'b0);
    vectors[5] = mk(1'b0, 1'b1, 32'h408, 32'h0F0F0F0F, 3,  32'h22222222, 32'h76543210, 1'b1, 5,  4,  1'b0);
    vectors[6] = mk(1'b1, 1'b0, 32'h40C, 32'h0,        15, 32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 17, 16, 1'b0);

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset.stall", 32'(stall), 32'd0);
    checkOutput("reset.busReq", 32'(bus_req), 32'd0);
    checkOutput("reset.busWe", 32'(bus_we), 32'd0);
    checkOutput("reset.busAddr", bus_addr, 32'd0);
    checkOutput("reset.busWdata", bus_wdata, 32'd0);
    checkOutput("reset.rdataOut", rdata_out, 32'd0);
    checkOutput("reset.busErr", 32'(bus_err), 32'd0);

    // Spurious ack while idle must not start or complete anything.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      #1;
      checkOutput("spuriousAck.stall", 32'(stall), 32'd0);
      checkOutput("spuriousAck.busReq", 32'(bus_req), 32'd0);
      checkOutput("spuriousAck.rdataOut", rdata_out, 32'd0);
    end
    bus_ack = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vectors[i], $sformatf("vec%0d", i));
    end

    // Reset in the second BUSY cycle aborts the load and clears the read result.
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h500; bus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_read = 1'b0;
    #1;
    checkOutput("resetBusy.busReq", 32'(bus_req), 32'd0);
    checkOutput("resetBusy.stall", 32'(stall), 32'd0);
    checkOutput("resetBusy.rdataOut", rdata_out, 32'd0);
    checkOutput("resetBusy.busAddr", bus_addr, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("resetBusy.stillIdle", 32'(stall | bus_req), 32'd0);

`ifdef DMEM_TIMEOUT_EN
    applyStimulus(mk(1'b1, 1'b0, 32'h600, 32'h0, 0, 32'h55AA55AA, 32'h55AA55AA, 1'b0, 2, 1, 1'b0), "preTimeout");
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h700; wdata = 32'h0; bus_ack = 1'b0;
    busyCount = 0;
    sawDone = 1'b0;
    for (int cyc = 0; cyc < 40 && !sawDone; cyc++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      if (bus_req) busyCount++;
      else sawDone = 1'b1;
    end
    checkOutput("timeout.reachedDone", 32'(sawDone), 32'd1);
    checkOutput("timeout.busyCycles", 32'(busyCount), 32'd16);
    checkOutput("timeout.doneStall", 32'(stall), 32'd0);
    checkOutput("timeout.busErr", 32'(bus_err), 32'd1);
    checkOutput("timeout.rdataOut", rdata_out, 32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    checkOutput("timeout.errHeld", 32'(bus_err), 32'd1);
    applyStimulus(mk(1'b1, 1'b0, 32'h704, 32'h0, 1, 32'h13579BDF, 32'h13579BDF, 1'b0, 3, 2, 1'b1), "postTimeout");
`else
    busyCount = 0;
    sawDone = 1'b0;
    applyStimulus(mk(1'b1, 1'b0, 32'h600, 32'h0, 24, 32'h2468ACE0, 32'h2468ACE0, 1'b0, 26, 25, 1'b0), "longWait");
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, BUSY-state cycle limit before abort; used only when DMEM_TIMEOUT_EN is defined.
REQ-002 clk  input  1  clock; all state changes on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_read  input  1  MEM-stage load request from the EX/MEM control register.
REQ-005 mem_write  input  1  MEM-stage store request from the EX/MEM control register.
REQ-006 addr  input  32  MEM-stage byte address.
REQ-007 wdata  input  32  MEM-stage store data.
REQ-008 stall  output  1  freezes the IF through MEM pipeline registers while high.
REQ-009 rdata_out  output  32  load result presented to the MEM/WB register.
REQ-010 bus_req  output  1  data-bus request, registered.
REQ-011 bus_we  output  1  1 = write transfer, 0 = read transfer, registered.
REQ-012 bus_addr  output  32  latched transfer address.
REQ-013 bus_wdata  output  32  latched store data.
REQ-014 bus_ack  input  1  single-cycle transfer completion from memory.
REQ-015 bus_rdata  input  32  read data, valid when bus_ack is high.
REQ-016 bus_err  output  1  sticky timeout flag.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-018 In IDLE with mem_read or mem_write high, the block SHALL latch addr, wdata and bus_we (bus_we = mem_write), then enter BUSY on the next edge.
REQ-019 When mem_read and mem_write are both high, the block SHALL perform a write.
REQ-020 stall SHALL be combinational: high when in IDLE with a request present, or when in BUSY; low otherwise.
REQ-021 bus_req SHALL be high in every BUSY cycle and low in IDLE and DONE.
REQ-022 bus_addr, bus_wdata and bus_we SHALL remain constant for the whole of BUSY.
REQ-023 In BUSY with bus_ack high, the block SHALL enter DONE; for a read, it SHALL capture bus_rdata into rdata_out on the same edge.
REQ-024 rdata_out SHALL hold its value until the next captured read.
REQ-025 DONE SHALL last exactly one cycle with stall low, and the block SHALL ignore mem_read and mem_write in that cycle.
REQ-026 From DONE, the FSM SHALL return to IDLE unconditionally.
REQ-027 The block SHALL ignore bus_ack in IDLE and DONE.
REQ-028 Minimum latency (ack in first BUSY cycle) SHALL be: stall high for 2 cycles, DONE on the 3rd cycle.
REQ-029 Back-to-back requests SHALL be separated by at least one DONE and one IDLE cycle.

Reset
REQ-030 Reset SHALL set: state = IDLE, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, rdata_out = 0, bus_err = 0.
REQ-031 A reset during BUSY SHALL abort the transfer; bus_req and stall SHALL be low in the cycle after the reset edge.

Configuration
REQ-032 Macro DMEM_TIMEOUT_EN defined: an 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-033 With DMEM_TIMEOUT_EN, after TIMEOUT_CYCLES BUSY cycles without ack, the block SHALL enter DONE, set rdata_out = 0 and set bus_err = 1; bus_err SHALL clear only on reset.
REQ-034 With DMEM_TIMEOUT_EN, if the ack arrives on the same cycle as the limit, the ack SHALL win and bus_err SHALL stay 0.
REQ-035 Macro DMEM_TIMEOUT_EN undefined: bus_err SHALL be tied to 0, no counter SHALL exist, and BUSY SHALL wait indefinitely.

Verification
REQ-036 Load: mem_read=1, addr=0x100; ack after 3 BUSY cycles with bus_rdata=0xCAFEF00D -> bus_req high 3 cycles, stall high 4 cycles, rdata_out=0xCAFEF00D in DONE.
REQ-037 Store: mem_write=1, addr=0x204, wdata=0x12345678; ack on first BUSY cycle -> bus_we=1, bus_wdata=0x12345678, stall high 2 cycles, rdata_out unchanged.
REQ-038 Both mem_read and mem_write high -> bus_we=1 (write performed).
REQ-039 Reset asserted in the 2nd BUSY cycle -> the next cycle shows IDLE, bus_req=0, stall=0, rdata_out=0.
REQ-040 DMEM_TIMEOUT_EN with no ack -> DONE after 16 BUSY cycles, bus_err=1 and held; a later normal load still completes with bus_err=1.
REQ-041 Spurious bus_ack=1 in IDLE with no request -> no state change, stall=0.
